vregs_file: RTL and testbench
=============================

Name: vregs_file

Overview:
- Parametrised successor of the 16x16x16 vector register file. Generic register count, element count and element width.
- Adds a per-element write port and a same-cycle write-to-read bypass option.
- Adds a per-register busy scoreboard for the issue stage, and a sweep state machine that zeroes every register after reset or on request.
- Sits between decode/issue (reads, reserve) and the vector execute/writeback stage (writes).

Parameters:
- NREGS, 16, number of vector registers (power of 2, >=2).
- NELEM, 16, elements per register (power of 2, >=2).
- EW, 16, element width in bits.
- BYPASS, 1, 1 = read ports return same-cycle write data; 0 = array contents only.
- Derived: RW=$clog2(NREGS), IW=$clog2(NELEM), LW=$clog2(NELEM+1), VW=NELEM*EW.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- clr  in  1  pulse: re-run the zeroing sweep.
- ready  out  1  high once the sweep has completed.
- rAddr0  in  RW  vector read port 0 address.
- rData0  out  VW  port 0 data (element i at bits [i*EW +: EW]).
- rLen0  out  LW  port 0 length.
- rAddr1, rData1, rLen1: same as port 0, for port 1.
- eAddr  in  RW  element read register.
- eIdx  in  IW  element read index.
- eData  out  EW  element read data.
- wEn  in  1  vector write enable.
- wAddr  in  RW  vector write register.
- wLen  in  LW  vector write length (values >NELEM saturate to NELEM).
- wData  in  VW  vector write data.
- weEn  in  1  element write enable.
- weAddr  in  RW  element write register.
- weIdx  in  IW  element write index.
- weData  in  EW  element write data.
- rsvEn  in  1  reserve enable.
- rsvAddr  in  RW  register to mark busy.
- busy  out  NREGS  per-register busy bits.

Behaviour:
- States: SWEEP, IDLE. Reset enters SWEEP with the sweep counter at 0.
- Reset values: ready=0, busy=0, state=SWEEP. The array has no reset; the sweep clears it.
- SWEEP: each cycle writes data[cnt]=0 and len[cnt]=0, then cnt++.
- SWEEP -> IDLE on the edge where cnt==NREGS-1. ready rises on that edge, exactly NREGS cycles after reset release.
- In SWEEP: wEn, weEn and rsvEn are ignored, all read outputs are forced to 0, and busy is held at 0.
- IDLE + clr: on the next edge, state=SWEEP, cnt=0, ready=0, busy=0. clr during SWEEP restarts cnt at 0.
- Reads are combinational, 0-cycle. eData = data[eAddr][eIdx], independent of length.
- Writes take effect at the clock edge (1-cycle latency).
- Vector write: data=wData, len=min(wLen,NELEM).
- Element write: lane weIdx=weData; len=max(len, weIdx+1); other lanes unchanged.
- Vector and element write to the same register in the same cycle:
  - lane weIdx takes weData, all other lanes take wData;
  - len=max(min(wLen,NELEM), weIdx+1).
- Writes to different registers in the same cycle: both are performed.
- BYPASS=1: a read whose address matches a same-cycle write returns the post-write value defined above (merged lanes and length). BYPASS=0: reads return array contents only.
- Scoreboard, applied per edge:
  - a write (wEn or weEn) to register r clears busy[r];
  - rsvEn sets busy[rsvAddr];
  - if a reserve and a write target the same register in the same cycle, the reserve wins and busy stays 1.
- Reserving an already-busy register leaves it busy; no error is flagged.
- Reset mid-operation: everything returns to the reset values; array contents are undefined until the sweep completes.

Decomposition:
- Package vregs_pkg:
  - default parameter constants;
  - state enum {SWEEP, IDLE};
  - function for the merged write lane/length.
- Sub-module vregs_scoreboard: busy bits, reserve/release, clr and sweep clearing.
- Array, sweep FSM and bypass logic stay in the top module.

Test Plan:
- Reset, then hold 16 cycles with wEn=1 -> ready=0 for cycles 1-15 and 1 at cycle 16; rData0=0 and rLen0=0 for all addresses; the writes are discarded.
- wEn, wAddr=3, wLen=5, wData lanes=0x0100+i -> next cycle rAddr0=3 gives those lanes and rLen0=5. With BYPASS=1, rAddr1=3 in the same cycle shows the same values.
- Reg 3 at len 5, weEn idx=9 data=0xBEEF -> rLen0=10, lane9=0xBEEF, lane4=0x0104; eAddr=3, eIdx=9 gives eData=0xBEEF.
- Same cycle: wEn reg 7 wLen=2 wData=0x1111 all lanes, and weEn reg 7 idx=4 data=0x2222 -> lane4=0x2222, other lanes 0x1111, len=5. wLen=20 -> len=16.
- rsvEn reg 2 -> busy=0x0004. Next cycle rsvEn reg 2 with wEn reg 2 -> busy[2] stays 1. Then wEn reg 2 alone -> busy=0.
- IDLE with data stored and busy=0x0004; clr pulse -> ready=0 and busy=0 next cycle; after 16 cycles ready=1 and all registers read 0 with len 0.

Source files
------------

// File: rtl/vregs_pkg.sv
// Shared constants, sweep FSM state type and the merged-length helper for the
// parametrised vector register file.
package vregs_pkg;

    localparam int DEF_NREGS  = 16;
    localparam int DEF_NELEM  = 16;
    localparam int DEF_EW     = 16;
    localparam int DEF_BYPASS = 1;

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } state_e;

    // Post-write length of one register: a vector write replaces the length
    // (saturated), an element write can only extend it to cover its lane.
    function automatic int unsigned merged_len(
        input int unsigned cur_len,
        input logic        w_hit,
        input int unsigned w_len,
        input logic        we_hit,
        input int unsigned we_idx,
        input int unsigned nelem
    );
        int unsigned len;
        len = w_hit ? ((w_len > nelem) ? nelem : w_len) : cur_len;
        if (we_hit && (we_idx + 1 > len)) begin
            len = we_idx + 1;
        end
        return len;
    endfunction

endpackage

// File: rtl/vregs_scoreboard.sv
// Per-register busy bits for the issue stage: reserve sets, writeback clears,
// reserve wins a same-cycle collision, clear_i wipes everything.
module vregs_scoreboard
    import vregs_pkg::*;
#(
    parameter int  NREGS = DEF_NREGS,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             wen_i,
    input  logic [RW-1:0]    waddr_i,
    input  logic             ween_i,
    input  logic [RW-1:0]    weaddr_i,
    input  logic             rsv_en_i,
    input  logic [RW-1:0]    rsv_addr_i,
    output logic [NREGS-1:0] busy_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
        logic rsv_hit;
        logic wr_hit;
        assign rsv_hit = rsv_en_i && (rsv_addr_i == RW'(gi));
        assign wr_hit  = (wen_i && (waddr_i == RW'(gi))) ||
                         (ween_i && (weaddr_i == RW'(gi)));
        assign busy_d[gi] = clear_i ? 1'b0 :
                            rsv_hit ? 1'b1 :
                            wr_hit  ? 1'b0 : busy_q[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/vregs_file.sv
// Parametrised vector register file: two vector read ports, one element read
// port, vector + element write ports with optional bypass, zeroing sweep FSM.
module vregs_file
    import vregs_pkg::*;
#(
    parameter int  NREGS  = DEF_NREGS,
    parameter int  NELEM  = DEF_NELEM,
    parameter int  EW     = DEF_EW,
    parameter int  BYPASS = DEF_BYPASS,
    localparam int RW     = $clog2(NREGS),
    localparam int IW     = $clog2(NELEM),
    localparam int LW     = $clog2(NELEM + 1),
    localparam int VW     = NELEM * EW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    output logic             ready,
    input  logic [RW-1:0]    rAddr0,
    output logic [VW-1:0]    rData0,
    output logic [LW-1:0]    rLen0,
    input  logic [RW-1:0]    rAddr1,
    output logic [VW-1:0]    rData1,
    output logic [LW-1:0]    rLen1,
    input  logic [RW-1:0]    eAddr,
    input  logic [IW-1:0]    eIdx,
    output logic [EW-1:0]    eData,
    input  logic             wEn,
    input  logic [RW-1:0]    wAddr,
    input  logic [LW-1:0]    wLen,
    input  logic [VW-1:0]    wData,
    input  logic             weEn,
    input  logic [RW-1:0]    weAddr,
    input  logic [IW-1:0]    weIdx,
    input  logic [EW-1:0]    weData,
    input  logic             rsvEn,
    input  logic [RW-1:0]    rsvAddr,
    output logic [NREGS-1:0] busy
);

    typedef logic [NELEM-1:0][EW-1:0] vec_t;

    state_e        state_q, state_d;
    logic [RW-1:0] cnt_q, cnt_d;
    logic          sweep;
    logic          w_ok, we_ok;

    vec_t          cur_data    [NREGS];
    vec_t          merged_data [NREGS];
    logic [LW-1:0] cur_len     [NREGS];
    logic [LW-1:0] merged_len_w[NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            SWEEP: begin
                if (clr) begin
                    cnt_d = '0;
                end else if (cnt_q == RW'(NREGS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (clr) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = SWEEP;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        sweep = (state_q == SWEEP);
        ready = (state_q == IDLE);
        w_ok  = wEn && !sweep;
        we_ok = weEn && !sweep;
    end

    // Each register computes its own post-write value; that value feeds both
    // the storage update and the bypassed read ports.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        vec_t          data_q;
        logic [LW-1:0] len_q;
        logic          w_hit, we_hit;

        assign w_hit  = w_ok  && (wAddr  == RW'(gi));
        assign we_hit = we_ok && (weAddr == RW'(gi));

        for (genvar gj = 0; gj < NELEM; gj++) begin : g_lane
            assign merged_data[gi][gj] = (we_hit && (weIdx == IW'(gj))) ? weData :
                                         w_hit ? wData[gj*EW +: EW] : data_q[gj];
        end

        assign merged_len_w[gi] = LW'(merged_len(32'(len_q), w_hit, 32'(wLen),
                                                 we_hit, 32'(weIdx), NELEM));

        always_ff @(posedge clk) begin
            if (sweep && (cnt_q == RW'(gi))) begin
                data_q <= '0;
                len_q  <= '0;
            end else if (w_hit || we_hit) begin
                data_q <= merged_data[gi];
                len_q  <= merged_len_w[gi];
            end
        end

        assign cur_data[gi] = data_q;
        assign cur_len[gi]  = len_q;
    end

    always_comb begin
        rData0 = '0;
        rLen0  = '0;
        rData1 = '0;
        rLen1  = '0;
        eData  = '0;
        if (!sweep) begin
            rData0 = (BYPASS != 0) ? merged_data[rAddr0]  : cur_data[rAddr0];
            rLen0  = (BYPASS != 0) ? merged_len_w[rAddr0] : cur_len[rAddr0];
            rData1 = (BYPASS != 0) ? merged_data[rAddr1]  : cur_data[rAddr1];
            rLen1  = (BYPASS != 0) ? merged_len_w[rAddr1] : cur_len[rAddr1];
            eData  = (BYPASS != 0) ? merged_data[eAddr][eIdx] : cur_data[eAddr][eIdx];
        end
    end

    vregs_scoreboard #(
        .NREGS(NREGS)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (sweep || clr),
        .wen_i     (w_ok),
        .waddr_i   (wAddr),
        .ween_i    (we_ok),
        .weaddr_i  (weAddr),
        .rsv_en_i  (rsvEn && !sweep),
        .rsv_addr_i(rsvAddr),
        .busy_o    (busy)
    );

endmodule

// File: tb/tb_vregs_file.sv
// Self-checking bench for vregs_file: reset sweep, table-driven write/read
// vectors with a scoreboard queue, and clr / restarted-sweep sequences.
module tb_vregs_file;

    localparam int NREGS = 16;
    localparam int NELEM = 16;
    localparam int EW    = 16;
    localparam int RW    = 4;
    localparam int IW    = 4;
    localparam int LW    = 5;
    localparam int VW    = NELEM * EW;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr;
    logic             ready;
    logic [RW-1:0]    rAddr0, rAddr1, eAddr;
    logic [VW-1:0]    rData0, rData1;
    logic [LW-1:0]    rLen0, rLen1;
    logic [IW-1:0]    eIdx;
    logic [EW-1:0]    eData;
    logic             wEn, weEn, rsvEn;
    logic [RW-1:0]    wAddr, weAddr, rsvAddr;
    logic [LW-1:0]    wLen;
    logic [VW-1:0]    wData;
    logic [IW-1:0]    weIdx;
    logic [EW-1:0]    weData;
    logic [NREGS-1:0] busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vregs_file #(
        .NREGS(NREGS), .NELEM(NELEM), .EW(EW), .BYPASS(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .ready(ready),
        .rAddr0(rAddr0), .rData0(rData0), .rLen0(rLen0),
        .rAddr1(rAddr1), .rData1(rData1), .rLen1(rLen1),
        .eAddr(eAddr), .eIdx(eIdx), .eData(eData),
        .wEn(wEn), .wAddr(wAddr), .wLen(wLen), .wData(wData),
        .weEn(weEn), .weAddr(weAddr), .weIdx(weIdx), .weData(weData),
        .rsvEn(rsvEn), .rsvAddr(rsvAddr), .busy(busy)
    );

    typedef struct {
        logic        wen;
        logic [3:0]  waddr;
        logic [4:0]  wlen;
        logic [15:0] wbase;
        logic        wramp;
        logic        ween;
        logic [3:0]  weaddr;
        logic [3:0]  weidx;
        logic [15:0] wedata;
        logic        rsv;
        logic [3:0]  rsvaddr;
        logic [3:0]  caddr;
        logic [3:0]  clane;
        logic [15:0] elane;
        logic [4:0]  elen;
        logic [15:0] ebusy;
    } vec_t;

    typedef struct {
        logic [3:0]  caddr;
        logic [3:0]  clane;
        logic [15:0] elane;
        logic [4:0]  elen;
        logic [15:0] ebusy;
    } exp_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];
    exp_t sb_q [$];

    function automatic vec_t mk(
        input logic wen, input logic [3:0] waddr, input logic [4:0] wlen,
        input logic [15:0] wbase, input logic wramp,
        input logic ween, input logic [3:0] weaddr, input logic [3:0] weidx,
        input logic [15:0] wedata, input logic rsv, input logic [3:0] rsvaddr,
        input logic [3:0] caddr, input logic [3:0] clane, input logic [15:0] elane,
        input logic [4:0] elen, input logic [15:0] ebusy);
        vec_t v;
        v.wen = wen; v.waddr = waddr; v.wlen = wlen; v.wbase = wbase; v.wramp = wramp;
        v.ween = ween; v.weaddr = weaddr; v.weidx = weidx; v.wedata = wedata;
        v.rsv = rsv; v.rsvaddr = rsvaddr; v.caddr = caddr; v.clane = clane;
        v.elane = elane; v.elen = elen; v.ebusy = ebusy;
        return v;
    endfunction

    function automatic logic [VW-1:0] build(input logic [15:0] base, input logic ramp);
        logic [VW-1:0] d;
        for (int i = 0; i < NELEM; i++) begin
            d[i*EW +: EW] = base + (ramp ? 16'(i) : 16'd0);
        end
        return d;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wEn = 1'b0; weEn = 1'b0; rsvEn = 1'b0; clr = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int r = 0; r < NREGS; r++) begin
            rAddr0 = RW'(r);
            #1;
            check({tag, "_data"}, 64'(rData0 != '0), 64'd0);
            check({tag, "_len"}, 64'(rLen0), 64'd0);
        end
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0; clr = 1'b0;
        rAddr0 = '0; rAddr1 = '0; eAddr = '0; eIdx = '0;
        wEn = 1'b1; wAddr = '0; wLen = 5'd16; wData = {VW{1'b1}};
        weEn = 1'b1; weAddr = 4'd2; weIdx = 4'd3; weData = 16'hFFFF;
        rsvEn = 1'b1; rsvAddr = 4'd1;

        vecs[0]  = mk(1, 3,  5, 16'h0100, 1, 0, 0, 0, 16'h0000, 0, 0, 3,  2, 16'h0102,  5, 16'h0000);
        vecs[1]  = mk(0, 0,  0, 16'h0000, 0, 1, 3, 9, 16'hBEEF, 0, 0, 3,  9, 16'hBEEF, 10, 16'h0000);
        vecs[2]  = mk(0, 0,  0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 3,  4, 16'h0104, 10, 16'h0000);
        vecs[3]  = mk(1, 7,  2, 16'h1111, 0, 1, 7, 4, 16'h2222, 0, 0, 7,  4, 16'h2222,  5, 16'h0000);
        vecs[4]  = mk(0, 0,  0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 7,  0, 16'h1111,  5, 16'h0000);
        vecs[5]  = mk(1, 7, 20, 16'h3333, 0, 0, 0, 0, 16'h0000, 0, 0, 7, 15, 16'h3333, 16, 16'h0000);
        vecs[6]  = mk(1, 6, 16, 16'h6666, 0, 1, 5, 0, 16'h00AA, 0, 0, 5,  0, 16'h00AA,  1, 16'h0000);
        vecs[7]  = mk(0, 0,  0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 6, 15, 16'h6666, 16, 16'h0000);
        vecs[8]  = mk(0, 0,  0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 2, 2,  0, 16'h0000,  0, 16'h0004);
        vecs[9]  = mk(1, 2,  3, 16'h2020, 0, 0, 0, 0, 16'h0000, 1, 2, 2,  1, 16'h2020,  3, 16'h0004);
        vecs[10] = mk(1, 2,  1, 16'h0202, 0, 0, 0, 0, 16'h0000, 0, 0, 2,  0, 16'h0202,  1, 16'h0000);
        vecs[11] = mk(0, 0,  0, 16'h0000, 0, 1, 3, 2, 16'h5555, 0, 0, 3,  2, 16'h5555, 10, 16'h0000);
        vecs[12] = mk(0, 0,  0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 2, 2,  0, 16'h0202,  1, 16'h0004);

        // Reset held with every write/reserve port active.
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        for (int c = 1; c <= 16; c++) begin
            @(posedge clk);
            #1;
            rAddr0 = RW'(c % NREGS);
            wAddr  = rAddr0;
            #1;
            check("sweep_ready", 64'(ready), 64'(c == 16));
            if (c < 16) begin
                check("sweep_rdata", 64'(rData0 != '0), 64'd0);
                check("sweep_rlen", 64'(rLen0), 64'd0);
                check("sweep_busy", 64'(busy), 64'd0);
            end else begin
                idle_inputs();
            end
        end
        $display("reset sweep done, ready=%0d", ready);
        check_all_zero("post_reset");
        check("post_reset_busy", 64'(busy), 64'd0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            wEn = vecs[i].wen; wAddr = vecs[i].waddr; wLen = vecs[i].wlen;
            wData = build(vecs[i].wbase, vecs[i].wramp);
            weEn = vecs[i].ween; weAddr = vecs[i].weaddr;
            weIdx = vecs[i].weidx; weData = vecs[i].wedata;
            rsvEn = vecs[i].rsv; rsvAddr = vecs[i].rsvaddr;
            e.caddr = vecs[i].caddr; e.clane = vecs[i].clane; e.elane = vecs[i].elane;
            e.elen = vecs[i].elen; e.ebusy = vecs[i].ebusy;
            sb_q.push_back(e);
            rAddr1 = vecs[i].caddr;
            #1;
            check("bypass_lane", 64'(rData1[vecs[i].clane*EW +: EW]), 64'(vecs[i].elane));
            check("bypass_len", 64'(rLen1), 64'(vecs[i].elen));

            @(negedge clk);
            idle_inputs();
            e = sb_q.pop_front();
            rAddr0 = e.caddr; eAddr = e.caddr; eIdx = e.clane;
            #1;
            check("rd_lane", 64'(rData0[e.clane*EW +: EW]), 64'(e.elane));
            check("rd_len", 64'(rLen0), 64'(e.elen));
            check("el_data", 64'(eData), 64'(e.elane));
            check("busy", 64'(busy), 64'(e.ebusy));
            $display("vec %0d: reg %0d lane %0d = %h len %0d busy %h",
                     i, e.caddr, e.clane, rData0[e.clane*EW +: EW], rLen0, busy);
        end

        // clr from IDLE, then a second clr part-way through the sweep.
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        check("clr_ready", 64'(ready), 64'd0);
        check("clr_busy", 64'(busy), 64'd0);
        @(negedge clk);
        clr = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("clr_sweep_ready", 64'(ready), 64'd0);
        end
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        check("restart_ready", 64'(ready), 64'd0);
        @(negedge clk);
        clr = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk);
            #1;
            check("restart_sweep_ready", 64'(ready), 64'(c == 16));
        end
        $display("clr sweep done, ready=%0d busy=%h", ready, busy);
        check_all_zero("post_clr");
        check("post_clr_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
